// File: rtl/uart_feeder_pkg.sv
// ============================================================================
//  Module      : uart_feeder_pkg
//  Description : Shared types and width helpers for the UART RX feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_GAP   = 3'd4
    } feeder_state_t;

    localparam logic c_TXD_IDLE = 1'b1;

    function automatic int timer_width(input int clk_div);
        return (clk_div > 2) ? $clog2(clk_div) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/feeder_fifo.sv
// ============================================================================
//  Module      : feeder_fifo
//  Description : Single-clock first-word-fall-through byte FIFO with
//                registered full/empty flags and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module feeder_fifo
    import uart_feeder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_ena,
    input  logic                   wr,
    input  logic [7:0]             din,
    input  logic                   rd,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_do_wr;
    logic          w_do_rd;
    logic [LW-1:0] w_count_next;

    assign w_do_wr = clk_ena & wr & ~r_full;
    assign w_do_rd = clk_ena & rd & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_next = r_count + LW'(1);
            2'b01:   w_count_next = r_count - LW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == LW'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_rx_feeder.sv
// ============================================================================
//  Module      : uart_rx_feeder
//  Description : Buffers parallel bytes and serialises them as 8N1/8N2 frames
//                with CTS back-pressure and a programmable inter-frame gap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_feeder
    import uart_feeder_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1,
    parameter int GAP_BITS   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_ena,
    input  logic                        wr_ena,
    input  logic [7:0]                  wr_data,
    input  logic                        cts_n,
    output logic                        txd,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        overflow
);

    localparam int              TW           = timer_width(CLK_DIV);
    localparam logic [TW-1:0]   c_TIMER_LAST = TW'(CLK_DIV - 1);
    localparam logic [3:0]      c_STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [3:0]      c_GAP_LAST   = 4'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

    feeder_state_t r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic [3:0]    r_bit_cnt, w_bit_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_txd, w_txd_next;
    logic          r_overflow;
    logic          w_pop;
    logic          w_bit_end;
    logic [7:0]    w_fifo_dout;

    feeder_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clk_ena (clk_ena),
        .wr      (wr_ena),
        .din     (wr_data),
        .rd      (w_pop),
        .dout    (w_fifo_dout),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign w_bit_end = (r_timer == c_TIMER_LAST);

    always_comb begin
        w_state_next   = r_state;
        w_timer_next   = r_timer;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_txd_next     = r_txd;
        w_pop          = 1'b0;

        if (r_state != ST_IDLE) begin
            w_timer_next = w_bit_end ? '0 : r_timer + TW'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (!empty && !cts_n) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_fifo_dout;
                    w_txd_next     = 1'b0;
                    w_timer_next   = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_txd_next     = r_shift[0];
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == 4'd7) begin
                        w_txd_next     = c_TXD_IDLE;
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_STOP;
                    end else begin
                        // Shift ahead so bit 0 always holds the bit on the line.
                        w_shift_next   = {1'b0, r_shift[7:1]};
                        w_txd_next     = r_shift[1];
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_STOP_LAST) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            ST_GAP: begin
                if (w_bit_end) begin
                    if (r_bit_cnt == c_GAP_LAST) begin
                        w_bit_cnt_next = '0;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                w_txd_next   = c_TXD_IDLE;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_txd      <= c_TXD_IDLE;
            r_overflow <= 1'b0;
        end else if (clk_ena) begin
            r_state   <= w_state_next;
            r_timer   <= w_timer_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_txd     <= w_txd_next;
            if (wr_ena && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign txd      = r_txd;
    assign busy     = (r_state != ST_IDLE);
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_feeder.sv
// ============================================================================
//  Module      : tb_uart_rx_feeder
//  Description : Randomised self-checking bench for uart_rx_feeder against a
//                queue-based line model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_feeder;

    localparam int CLK_DIV   = 4;
    localparam int DEPTH     = 4;
    localparam int STOP_BITS = 2;
    localparam int GAP_BITS  = 3;
    localparam int FRAME     = (1 + 8 + STOP_BITS + GAP_BITS) * CLK_DIV;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     clk_ena = 1'b1;
    logic                     wr_ena = 1'b0;
    logic [7:0]               wr_data = 8'h00;
    logic                     cts_n = 1'b1;
    logic                     txd;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     busy;
    logic                     overflow;

    always #5 clk = ~clk;

    uart_rx_feeder #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (STOP_BITS),
        .GAP_BITS   (GAP_BITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_ena  (clk_ena),
        .wr_ena   (wr_ena),
        .wr_data  (wr_data),
        .cts_n    (cts_n),
        .txd      (txd),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: byte queue plus a frame position counted in enabled cycles.
    logic [7:0] q[$];
    bit         m_ovf    = 1'b0;
    bit         m_active = 1'b0;
    int         m_idx    = 0;
    logic [7:0] m_cur    = 8'h00;
    logic       m_last_txd = 1'b1;
    int         m_cycle  = 0;
    int         n_frames = 0;
    int         starts[$];

    function automatic logic exp_line(input int idx, input logic [7:0] b);
        int bitn;
        bitn = idx / CLK_DIV;
        if (bitn == 0) return 1'b0;
        if (bitn <= 8) return b[bitn-1];
        return 1'b1;
    endfunction

    initial begin
        bit full_prev;
        bit start_exp;
        forever begin
            @(posedge clk);
            #1;
            m_cycle++;
            if (rst) begin
                q.delete();
                m_ovf    = 1'b0;
                m_active = 1'b0;
                check("rst_txd", txd, 1);
                check("rst_busy", busy, 0);
                check("rst_ovf", overflow, 0);
            end else if (!clk_ena) begin
                check("hold_txd", txd, m_last_txd);
            end else begin
                full_prev = (q.size() == DEPTH);
                start_exp = !m_active && (q.size() != 0) && !cts_n;
                if (m_active) begin
                    m_idx++;
                    if (m_idx == FRAME) begin
                        m_active = 1'b0;
                        check("frame_end_txd", txd, 1);
                        check("frame_end_busy", busy, 0);
                    end else begin
                        check("line", txd, exp_line(m_idx, m_cur));
                        check("busy", busy, 1);
                    end
                end else begin
                    check("start", txd, start_exp ? 0 : 1);
                    check("idle_busy", busy, start_exp);
                    if (start_exp) begin
                        m_cur    = q.pop_front();
                        m_active = 1'b1;
                        m_idx    = 0;
                        n_frames++;
                        starts.push_back(m_cycle);
                    end
                end
                if (wr_ena) begin
                    if (full_prev) m_ovf = 1'b1;
                    else           q.push_back(wr_data);
                end
            end
            check("level", level, q.size());
            check("full", full, (q.size() == DEPTH));
            check("empty", empty, (q.size() == 0));
            check("overflow", overflow, m_ovf);
            m_last_txd = txd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_ena  = 1'b1;
        wr_data = b;
        tick(1);
        wr_ena  = 1'b0;
    endtask

    initial begin
        int base;
        int waited;
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_level", level, 0);
        check("reset_empty", empty, 1);

        // Single byte latency: empty clears after the write, txd falls one cycle later.
        cts_n = 1'b0;
        write_byte(8'($urandom));
        check("lat_empty", empty, 0);
        check("lat_txd_hi", txd, 1);
        tick(1);
        check("lat_txd_lo", txd, 0);
        check("lat_level", level, 0);
        tick(FRAME + 5);

        // Fill past full with CTS held off, then drain.
        cts_n = 1'b1;
        base = n_frames;
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        check("fill_full", full, 1);
        check("fill_level", level, DEPTH);
        check("fill_ovf", overflow, 1);
        tick(100);
        check("cts_hold", n_frames - base, 0);
        cts_n = 1'b0;
        tick(DEPTH * (FRAME + 1) + 10);
        check("drained", n_frames - base, DEPTH);

        // CTS dropped mid-frame lets the current frame finish but withholds the next.
        cts_n = 1'b1;
        base = n_frames;
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        tick(100);
        cts_n = 1'b0;
        tick(10);
        cts_n = 1'b1;
        tick(2 * FRAME);
        check("cts_one_frame", n_frames - base, 1);
        cts_n = 1'b0;
        tick(FRAME + 10);
        check("cts_two_frames", n_frames - base, 2);

        // Start-to-start spacing with two bytes queued.
        cts_n = 1'b1;
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        base = starts.size();
        cts_n = 1'b0;
        tick(2 * FRAME + 10);
        if (starts.size() >= base + 2)
            check("spacing", starts[base+1] - starts[base], FRAME + 1);
        else
            check("spacing_frames", starts.size() - base, 2);

        // Writes while disabled are ignored; 50% enable stretches bits.
        clk_ena = 1'b0;
        write_byte(8'($urandom));
        check("dis_write_level", level, 0);
        clk_ena = 1'b1;
        base = n_frames;
        write_byte(8'($urandom));
        for (int i = 0; i < 2 * FRAME + 20; i++) begin
            clk_ena = i[0];
            tick(1);
        end
        clk_ena = 1'b1;
        tick(5);
        check("gated_frame", n_frames - base, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            clk_ena = ($urandom_range(0, 3) != 0);
            wr_ena  = ($urandom_range(0, 15) == 0);
            wr_data = 8'($urandom);
            if ($urandom_range(0, 199) == 0) cts_n = ~cts_n;
            tick(1);
        end
        wr_ena  = 1'b0;
        clk_ena = 1'b1;
        cts_n   = 1'b0;
        tick(DEPTH * (FRAME + 1) + 10);

        // Reset during data bit 3 aborts the frame and discards the queue.
        cts_n = 1'b1;
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        cts_n = 1'b0;
        waited = 0;
        while (!(m_active && (m_idx / CLK_DIV) == 4) && waited < 200) begin
            tick(1);
            waited++;
        end
        check("reach_data3", waited < 200, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_txd", txd, 1);
        check("mid_rst_level", level, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovf", overflow, 0);
        base = n_frames;
        tick(2 * FRAME);
        check("no_restart", n_frames - base, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
